// File: rtl/ghostbus_ram_pkg.sv
// Shared helpers for the banked ghostbus RAM: address-window decode and sizing functions.
package ghostbus_ram_pkg;

  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int span_of(input int nbanks, input int ram_aw);
    return nbanks * (2 ** ram_aw);
  endfunction

  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
    return (addr >= base) && (addr < (base + span));
  endfunction

endpackage

// File: rtl/ghostbus_ram_sp.sv
// One RAM bank: single-port storage with a registered read and a host/local input select.
module ghostbus_ram_sp
  import ghostbus_ram_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_sel_host,
  input  logic          i_h_en,
  input  logic          i_h_we,
  input  logic [AW-1:0] i_h_addr,
  input  logic [DW-1:0] i_h_wdata,
  input  logic          i_l_en,
  input  logic          i_l_we,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic [DW-1:0] o_rdata
);

  logic          w_en;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_comb begin
    w_en    = i_l_en;
    w_we    = i_l_we;
    w_addr  = i_l_addr;
    w_wdata = i_l_wdata;
    if (i_sel_host) begin
      w_en    = i_h_en;
      w_we    = i_h_we;
      w_addr  = i_h_addr;
      w_wdata = i_h_wdata;
    end
  end

  // The read captures the stored word before any same-edge write lands.
  always_ff @(posedge i_clk) begin
    if (w_en) begin
      r_rdata <= r_mem[w_addr];
      if (w_we) r_mem[w_addr] <= w_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ghostbus_ram_banked.sv
// Banked ghostbus RAM window shared with a local application port; the host wins per bank.
module ghostbus_ram_banked
  import ghostbus_ram_pkg::*;
#(
  parameter int            AW     = 24,
  parameter int            DW     = 32,
  parameter int            RAM_DW = 8,
  parameter int            RAM_AW = 6,
  parameter int            NBANKS = 2,
  parameter logic [AW-1:0] BASE   = 'h100,
  parameter int            RD_LAT = 1,
  localparam int           BW     = clog2_min1(NBANKS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [AW-1:0]        i_gb_addr,
  input  logic [DW-1:0]        i_gb_dout,
  input  logic                 i_gb_we,
  input  logic                 i_gb_re,
  output logic [DW-1:0]        o_gb_din,
  output logic                 o_gb_rvalid,
  input  logic [BW+RAM_AW-1:0] i_lcl_addr,
  input  logic [RAM_DW-1:0]    i_lcl_wdata,
  input  logic                 i_lcl_we,
  input  logic                 i_lcl_re,
  output logic                 o_lcl_stall,
  output logic [RAM_DW-1:0]    o_lcl_rdata,
  output logic                 o_lcl_rvalid
);

  localparam int SPAN = span_of(NBANKS, RAM_AW);

  logic              w_hostHit;
  logic              w_hostRead;
  logic [BW-1:0]     w_hostBank;
  logic              w_lclReq;
  logic              w_lclStall;
  logic              w_lclGo;
  logic              w_lclRead;
  logic [BW-1:0]     w_lclBank;
  logic [RAM_DW-1:0] w_bankRdata [NBANKS];
  logic [RAM_DW-1:0] w_hRam;
  logic [RAM_DW-1:0] w_lRam;
  logic [RAM_DW-1:0] w_hOut;
  logic [RAM_DW-1:0] w_lOut;
  logic [RD_LAT-1:0] r_hValid;
  logic [RD_LAT-1:0] r_lValid;
  logic [BW-1:0]     r_hBank;
  logic [BW-1:0]     r_lBank;
  logic              w_unused;

  assign w_hostHit  = (i_gb_we | i_gb_re) && in_window(64'(i_gb_addr), 64'(BASE), 64'(SPAN));
  assign w_hostRead = w_hostHit & i_gb_re;
  assign w_hostBank = (NBANKS == 1) ? '0 : i_gb_addr[RAM_AW +: BW];

  assign w_lclReq   = i_lcl_we | i_lcl_re;
  assign w_lclBank  = (NBANKS == 1) ? '0 : i_lcl_addr[RAM_AW +: BW];
  assign w_lclStall = w_lclReq && w_hostHit && (w_hostBank == w_lclBank);
  assign w_lclGo    = w_lclReq && !w_lclStall;
  assign w_lclRead  = w_lclGo & i_lcl_re;
  assign o_lcl_stall = w_lclStall;

  assign w_unused = ^{i_gb_dout, i_lcl_addr};

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic w_selHost;
    logic w_selLcl;
    assign w_selHost = w_hostHit && (w_hostBank == BW'(b));
    assign w_selLcl  = w_lclGo && (w_lclBank == BW'(b));
    ghostbus_ram_sp #(.DW(RAM_DW), .AW(RAM_AW)) u_ram (
      .i_clk      (i_clk),
      .i_sel_host (w_selHost),
      .i_h_en     (w_selHost),
      .i_h_we     (i_gb_we),
      .i_h_addr   (i_gb_addr[RAM_AW-1:0]),
      .i_h_wdata  (i_gb_dout[RAM_DW-1:0]),
      .i_l_en     (w_selLcl),
      .i_l_we     (i_lcl_we),
      .i_l_addr   (i_lcl_addr[RAM_AW-1:0]),
      .i_l_wdata  (i_lcl_wdata),
      .o_rdata    (w_bankRdata[b])
    );
  end

  // Valid bits shift one stage per cycle; reset drops anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hValid <= '0;
      r_lValid <= '0;
    end else begin
      r_hValid <= (r_hValid << 1) | RD_LAT'(w_hostRead);
      r_lValid <= (r_lValid << 1) | RD_LAT'(w_lclRead);
    end
  end

  always_ff @(posedge i_clk) begin
    r_hBank <= w_hostBank;
    r_lBank <= w_lclBank;
  end

  assign w_hRam = w_bankRdata[r_hBank];
  assign w_lRam = w_bankRdata[r_lBank];

  if (RD_LAT > 1) begin : g_dly
    logic [RAM_DW-1:0] r_hData [RD_LAT-1];
    logic [RAM_DW-1:0] r_lData [RD_LAT-1];
    always_ff @(posedge i_clk) begin
      r_hData[0] <= w_hRam;
      r_lData[0] <= w_lRam;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        r_hData[i] <= r_hData[i-1];
        r_lData[i] <= r_lData[i-1];
      end
    end
    assign w_hOut = r_hData[RD_LAT-2];
    assign w_lOut = r_lData[RD_LAT-2];
  end else begin : g_nodly
    assign w_hOut = w_hRam;
    assign w_lOut = w_lRam;
  end

  assign o_gb_rvalid  = r_hValid[RD_LAT-1];
  assign o_gb_din     = o_gb_rvalid ? DW'(w_hOut) : '0;
  assign o_lcl_rvalid = r_lValid[RD_LAT-1];
  assign o_lcl_rdata  = o_lcl_rvalid ? w_lOut : '0;

endmodule

// File: tb/tb_ghostbus_ram_banked.sv
// Scoreboard bench driving one stimulus stream into RD_LAT=1 and RD_LAT=3 instances side by side.
module tb_ghostbus_ram_banked;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] gbAddr;
  logic [31:0] gbDout;
  logic        gbWe, gbRe;
  logic [6:0]  lclAddr;
  logic [7:0]  lclWdata;
  logic        lclWe, lclRe;

  logic [31:0] aGbDin, bGbDin;
  logic        aGbRvalid, bGbRvalid;
  logic        aLclStall, bLclStall;
  logic [7:0]  aLclRdata, bLclRdata;
  logic        aLclRvalid, bLclRvalid;

  int          cyc = 0;
  int          checkCount = 0;
  int          errorCount = 0;
  bit          started = 0;
  logic [7:0]  model [128];
  sbEntry_t    sbQ [4][$];
  string       streamName [4];

  ghostbus_ram_banked #(.RD_LAT(1)) dutA (
    .i_clk(clk), .i_rst(rst),
    .i_gb_addr(gbAddr), .i_gb_dout(gbDout), .i_gb_we(gbWe), .i_gb_re(gbRe),
    .o_gb_din(aGbDin), .o_gb_rvalid(aGbRvalid),
    .i_lcl_addr(lclAddr), .i_lcl_wdata(lclWdata), .i_lcl_we(lclWe), .i_lcl_re(lclRe),
    .o_lcl_stall(aLclStall), .o_lcl_rdata(aLclRdata), .o_lcl_rvalid(aLclRvalid)
  );

  ghostbus_ram_banked #(.RD_LAT(3)) dutB (
    .i_clk(clk), .i_rst(rst),
    .i_gb_addr(gbAddr), .i_gb_dout(gbDout), .i_gb_we(gbWe), .i_gb_re(gbRe),
    .o_gb_din(bGbDin), .o_gb_rvalid(bGbRvalid),
    .i_lcl_addr(lclAddr), .i_lcl_wdata(lclWdata), .i_lcl_we(lclWe), .i_lcl_re(lclRe),
    .o_lcl_stall(bLclStall), .o_lcl_rdata(bLclRdata), .o_lcl_rvalid(bLclRvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic pushExpect(input int s, input int due, input logic [31:0] data);
    sbEntry_t e;
    e.cyc  = due;
    e.data = data;
    sbQ[s].push_back(e);
  endtask

  // Each valid pulse must match the oldest pending read both in data and arrival cycle.
  task automatic monitorStream(input int s, input logic valid, input logic [31:0] data);
    sbEntry_t e;
    if (valid === 1'b1) begin
      if (sbQ[s].size() == 0) begin
        checkOutput({streamName[s], "_unexpected_rvalid"}, 32'd1, 32'd0);
      end else begin
        e = sbQ[s].pop_front();
        checkOutput({streamName[s], "_latency"}, cyc, e.cyc);
        checkOutput({streamName[s], "_data"}, data, e.data);
      end
    end else begin
      checkOutput({streamName[s], "_idle_zero"}, data, 32'd0);
      if (sbQ[s].size() > 0 && sbQ[s][0].cyc <= cyc) begin
        e = sbQ[s].pop_front();
        checkOutput({streamName[s], "_missing_rvalid"}, 32'd0, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      monitorStream(0, aGbRvalid, aGbDin);
      monitorStream(1, aLclRvalid, 32'(aLclRdata));
      monitorStream(2, bGbRvalid, bGbDin);
      monitorStream(3, bLclRvalid, 32'(bLclRdata));
    end
  end

  // One clock of stimulus: drive, check stall, predict reads, update the memory model.
  task automatic applyStimulus(input logic [23:0] gA, input logic [31:0] gD, input logic gW, input logic gR,
                               input logic [6:0] lA, input logic [7:0] lD, input logic lW, input logic lR,
                               input logic r);
    logic        hHit, lReq, expStall, lGo;
    logic [23:0] off;
    logic [6:0]  hIdx;
    logic [7:0]  hOld, lOld;
    gbAddr = gA; gbDout = gD; gbWe = gW; gbRe = gR;
    lclAddr = lA; lclWdata = lD; lclWe = lW; lclRe = lR;
    rst = r;
    #1;
    off      = gA - 24'h100;
    hIdx     = off[6:0];
    hHit     = (gW | gR) && (gA >= 24'h100) && (gA < 24'h180);
    lReq     = lW | lR;
    expStall = lReq && hHit && (hIdx[6] == lA[6]);
    lGo      = lReq && !expStall;
    checkOutput("A_lcl_stall", 32'(aLclStall), 32'(expStall));
    checkOutput("B_lcl_stall", 32'(bLclStall), 32'(expStall));
    hOld = model[hIdx];
    lOld = model[lA];
    if (hHit && gR) begin
      pushExpect(0, cyc + 1, 32'(hOld));
      pushExpect(2, cyc + 3, 32'(hOld));
    end
    if (lGo && lR) begin
      pushExpect(1, cyc + 1, 32'(lOld));
      pushExpect(3, cyc + 3, 32'(lOld));
    end
    if (hHit && gW) model[hIdx] = gD[7:0];
    if (lGo && lW) model[lA] = lD;
    if (r) begin
      for (int s = 0; s < 4; s++)
        while (sbQ[s].size() > 0 && sbQ[s][sbQ[s].size()-1].cyc > cyc)
          void'(sbQ[s].pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(24'h0, 32'h0, 0, 0, 7'h0, 8'h0, 0, 0, 0);
  endtask

  task automatic hostWrite(input logic [23:0] a, input logic [31:0] d);
    applyStimulus(a, d, 1, 0, 7'h0, 8'h0, 0, 0, 0);
  endtask

  task automatic hostRead(input logic [23:0] a);
    applyStimulus(a, 32'h0, 0, 1, 7'h0, 8'h0, 0, 0, 0);
  endtask

  task automatic applyReset();
    applyStimulus(24'h0, 32'h0, 0, 0, 7'h0, 8'h0, 0, 0, 1);
  endtask

  initial begin
    streamName[0] = "A_gb";
    streamName[1] = "A_lcl";
    streamName[2] = "B_gb";
    streamName[3] = "B_lcl";
    for (int i = 0; i < 128; i++) model[i] = 8'h0;

    applyReset();
    started = 1;
    applyReset();
    checkOutput("rst_A_gb_rvalid", 32'(aGbRvalid), 32'd0);
    checkOutput("rst_A_gb_din", aGbDin, 32'd0);
    checkOutput("rst_B_lcl_rvalid", 32'(bLclRvalid), 32'd0);
    checkOutput("rst_B_lcl_rdata", 32'(bLclRdata), 32'd0);

    for (int i = 0; i < 128; i++) hostWrite(24'h100 + 24'(i), $urandom);

    hostWrite(24'h100, 32'h5A);
    hostWrite(24'h140, 32'h77);
    hostWrite(24'h105, 32'hDEADBEA5);
    hostRead(24'h105);
    hostRead(24'h140);
    idle(4);

    hostRead(24'h0FF);
    hostRead(24'h180);
    hostWrite(24'h180, 32'hFF);
    hostRead(24'h100);
    idle(4);

    applyStimulus(24'h110, 32'h3C, 1, 0, 7'h10, 8'h0, 0, 1, 0);
    applyStimulus(24'h0, 32'h0, 0, 0, 7'h10, 8'h0, 0, 1, 0);
    idle(4);

    applyStimulus(24'h101, 32'h66, 1, 0, 7'h43, 8'h99, 1, 0, 0);
    applyStimulus(24'h143, 32'h0, 0, 1, 7'h01, 8'h0, 0, 1, 0);
    idle(4);

    hostWrite(24'h102, 32'hC2);
    hostWrite(24'h103, 32'hC3);
    for (int i = 0; i < 4; i++) hostRead(24'h100 + 24'(i));
    idle(5);

    hostWrite(24'h120, 32'h11);
    applyStimulus(24'h120, 32'h22, 1, 1, 7'h0, 8'h0, 0, 0, 0);
    hostRead(24'h120);
    idle(4);

    applyStimulus(24'h0, 32'h0, 0, 0, 7'h30, 8'h44, 1, 0, 0);
    applyStimulus(24'h0, 32'h0, 0, 0, 7'h30, 8'h55, 1, 1, 0);
    applyStimulus(24'h0, 32'h0, 0, 0, 7'h30, 8'h00, 0, 1, 0);
    idle(4);

    hostRead(24'h105);
    applyReset();
    idle(2);
    applyStimulus(24'h105, 32'h0, 0, 1, 7'h45, 8'h0, 0, 1, 1);
    idle(4);
    hostRead(24'h105);
    idle(4);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(24'($urandom_range(32'h0F0, 32'h18F)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    idle(6);

    for (int s = 0; s < 4; s++) checkOutput({streamName[s], "_drained"}, 32'(sbQ[s].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
